uart_rx_sipo: RTL and testbench

- UART receiver, serial-in parallel-out (SIPO).
- Receives the 8N1 serial stream produced by the transmit side: start bit (0), 8 data bits LSB first, stop bit (1); idle line is high.
- Oversamples the line with a fixed clocks-per-bit count and samples at mid-bit.
- Presents each received byte with a one-cycle valid strobe, and flags framing errors.

---
 rtl/uart_rx_sipo_if.sv | 19 +
 rtl/uart_rx_sipo.sv | 123 ++++++++++++
 tb/tb_uart_rx_sipo.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_sipo_if.sv
// uart_rx_sipo_if: serial line plus receive-side outputs of the UART receiver.
//   din       : serial line into the receiver (idle high)
//   dout      : last correctly received byte
//   valid     : one-cycle strobe, dout updated
//   frame_err : one-cycle strobe, stop bit sampled low
//   busy      : frame in progress
// master = line driver / byte consumer, slave = receiver.
interface uart_rx_sipo_if #(
  parameter int DATA_BITS = 8
);
  logic                 din;
  logic [DATA_BITS-1:0] dout;
  logic                 valid;
  logic                 frame_err;
  logic                 busy;

  modport master (output din, input dout, valid, frame_err, busy);
  modport slave  (input din, output dout, valid, frame_err, busy);
endinterface

// File: rtl/uart_rx_sipo.sv
// uart_rx_sipo: 8N1 UART receiver, serial-in parallel-out.
// Oversamples the line at CLKS_PER_BIT clocks per bit, samples mid-bit,
// presents each byte with a one-cycle valid strobe and flags bad stop bits.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : uart_rx_sipo_if.slave (din in; dout/valid/frame_err/busy out)
module uart_rx_sipo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_sipo_if.slave  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t               r_state, w_next;
  logic [1:0]           r_sync;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_dout;
  logic                 r_valid;
  logic                 r_ferr;

  logic w_rx;
  logic w_cnt_clr, w_idx_clr, w_shift, w_done_ok, w_done_err;

  // Two-flop synchronizer; resets to the idle-line level so reset never
  // looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], bus.din};
  end
  assign w_rx = r_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Counter is cleared on every sample point, so each later sample lands
  // exactly CLKS_PER_BIT cycles after the previous one.
  always_comb begin
    w_next     = r_state;
    w_cnt_clr  = 1'b0;
    w_idx_clr  = 1'b0;
    w_shift    = 1'b0;
    w_done_ok  = 1'b0;
    w_done_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_clr = 1'b1;
        if (!w_rx) w_next = S_START;
      end
      S_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_clr = 1'b1;
          w_idx_clr = 1'b1;
          w_next    = w_rx ? S_IDLE : S_DATA;  // high mid-start = glitch
        end
      end
      S_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_clr = 1'b1;
          w_shift   = 1'b1;
          if (r_idx == IDX_LAST) w_next = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_clr = 1'b1;
          if (w_rx) begin
            w_done_ok = 1'b1;
            w_next    = S_IDLE;
          end else begin
            w_done_err = 1'b1;
            w_next     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Line held low after a bad stop: wait for it to go high so the
        // low level is not mistaken for a new start bit.
        w_cnt_clr = 1'b1;
        if (w_rx) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + CW'(1);
      if (w_idx_clr)    r_idx <= '0;
      else if (w_shift) r_idx <= r_idx + IW'(1);
      if (w_shift) r_shift[r_idx] <= w_rx;
      r_valid <= w_done_ok;
      r_ferr  <= w_done_err;
      if (w_done_ok) r_dout <= r_shift;
    end
  end

  assign bus.dout      = r_dout;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_ferr;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_sipo.sv
// tb_uart_rx_sipo: self-checking bench for uart_rx_sipo (CLKS_PER_BIT = 4).
// Frames are described by their byte and stop-bit level; the expected
// strobe kind, byte, and din-to-strobe latency come from a queue of those
// descriptions. Directed table, hand sequences, then random frames.
module tb_uart_rx_sipo;
  localparam int CPB = 4;
  localparam int DB  = 8;
  localparam int LAT = CPB/2 + (DB+1)*CPB + 1 + 2;  // din low -> strobe

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_sipo_if #(.DATA_BITS(DB)) bus ();
  uart_rx_sipo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic err; logic [7:0] data; int t0; } exp_t;
  exp_t q[$];

  int n_chk = 0, n_err = 0;
  int n_valid = 0, n_ferr = 0, v_last = 0, v_prev = 0;
  logic [7:0] m_dout = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst && (bus.valid || bus.frame_err)) begin
      exp_t e;
      if (bus.valid && bus.frame_err) chk("valid_with_ferr", 1, 0);
      if (bus.valid) begin n_valid++; v_prev = v_last; v_last = cyc; end
      if (bus.frame_err) n_ferr++;
      if (q.size() == 0) chk("unexpected_strobe", 1, 0);
      else begin
        e = q.pop_front();
        chk("strobe_kind", int'(bus.frame_err), int'(e.err));
        chk("latency", cyc - e.t0, LAT);
        if (!e.err) begin
          chk("dout", int'(bus.dout), int'(e.data));
          m_dout = e.data;
        end else chk("dout_hold", int'(bus.dout), int'(m_dout));
      end
    end
  end

  task automatic bit_out(input logic v);
    bus.din = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Call on a negedge. Leaves din at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    exp_t e;
    e.err = !stop_ok; e.data = b; e.t0 = cyc;
    q.push_back(e);
    bit_out(1'b0);
    for (int i = 0; i < DB; i++) bit_out(b[i]);
    bit_out(stop_ok);
  endtask

  typedef struct {
    logic [7:0] data; logic stop_ok; int gap;
    int nv; int ne; logic [7:0] exp_dout;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv0, ne0;
    tbl[0] = '{8'h00, 1'b1, 0, 1, 0, 8'h00};
    tbl[1] = '{8'hFF, 1'b1, 1, 1, 0, 8'hFF};
    tbl[2] = '{8'h55, 1'b1, 3, 1, 0, 8'h55};
    tbl[3] = '{8'hAA, 1'b0, 2, 0, 1, 8'h55};
    tbl[4] = '{8'h01, 1'b1, 0, 1, 0, 8'h01};
    tbl[5] = '{8'h80, 1'b1, 2, 1, 0, 8'h80};

    // 1: reset and idle
    bus.din = 1'b1;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_dout", int'(bus.dout), 0);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_ferr", int'(bus.frame_err), 0);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("idle_valid_cnt", n_valid, 0);
    chk("idle_ferr_cnt", n_ferr, 0);
    chk("idle_busy", int'(bus.busy), 0);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      nv0 = n_valid; ne0 = n_ferr;
      send_frame(tbl[i].data, tbl[i].stop_ok);
      bus.din = 1'b1;
      repeat (4 + tbl[i].gap) @(negedge clk);
      chk($sformatf("tbl%0d_valid_cnt", i), n_valid - nv0, tbl[i].nv);
      chk($sformatf("tbl%0d_ferr_cnt", i), n_ferr - ne0, tbl[i].ne);
      chk($sformatf("tbl%0d_dout", i), int'(bus.dout), int'(tbl[i].exp_dout));
      chk($sformatf("tbl%0d_busy", i), int'(bus.busy), 0);
    end

    // 2: 0x58, busy across the frame
    nv0 = n_valid; ne0 = n_ferr;
    send_frame(8'h58, 1'b1);
    bus.din = 1'b1;
    chk("t2_busy_mid", int'(bus.busy), 1);
    repeat (3) @(negedge clk);
    chk("t2_busy_end", int'(bus.busy), 0);
    chk("t2_dout", int'(bus.dout), 8'h58);
    chk("t2_valid_cnt", n_valid - nv0, 1);
    chk("t2_ferr_cnt", n_ferr - ne0, 0);

    // 3: back-to-back 0xA5, 0x3C
    nv0 = n_valid;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    bus.din = 1'b1;
    repeat (4) @(negedge clk);
    chk("t3_valid_cnt", n_valid - nv0, 2);
    chk("t3_spacing", v_last - v_prev, 10*CPB);
    chk("t3_dout", int'(bus.dout), 8'h3C);

    // 4: one-cycle glitch
    nv0 = n_valid; ne0 = n_ferr;
    bus.din = 1'b0;
    @(negedge clk);
    bus.din = 1'b1;
    repeat (2) @(negedge clk);
    chk("t4_busy_start", int'(bus.busy), 1);
    repeat (10) @(negedge clk);
    chk("t4_busy_end", int'(bus.busy), 0);
    chk("t4_valid_cnt", n_valid - nv0, 0);
    chk("t4_ferr_cnt", n_ferr - ne0, 0);
    chk("t4_dout", int'(bus.dout), 8'h3C);

    // 5: bad stop, line held low, then good frame
    nv0 = n_valid; ne0 = n_ferr;
    send_frame(8'h81, 1'b0);
    repeat (20) @(negedge clk);
    chk("t5_busy_hold", int'(bus.busy), 1);
    chk("t5_ferr_cnt", n_ferr - ne0, 1);
    chk("t5_valid_cnt_hold", n_valid - nv0, 0);
    chk("t5_dout_hold", int'(bus.dout), 8'h3C);
    bus.din = 1'b1;
    repeat (8) @(negedge clk);
    chk("t5_busy_released", int'(bus.busy), 0);
    send_frame(8'h42, 1'b1);
    bus.din = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_dout", int'(bus.dout), 8'h42);
    chk("t5_valid_cnt", n_valid - nv0, 1);
    chk("t5_ferr_cnt_end", n_ferr - ne0, 1);

    // 6: reset mid-frame of 0xFF
    nv0 = n_valid; ne0 = n_ferr;
    bit_out(1'b0);
    bit_out(1'b1); bit_out(1'b1); bit_out(1'b1);
    chk("t6_busy_mid", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_dout", int'(bus.dout), 0);
    chk("t6_rst_busy", int'(bus.busy), 0);
    chk("t6_rst_valid", int'(bus.valid), 0);
    chk("t6_rst_ferr", int'(bus.frame_err), 0);
    m_dout = 8'h00;
    bus.din = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_no_strobe", (n_valid - nv0) + (n_ferr - ne0), 0);
    send_frame(8'h11, 1'b1);
    bus.din = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_dout", int'(bus.dout), 8'h11);

    // Random frames; after a bad stop the line must return high before
    // the next start bit.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      logic ok;
      int gap;
      b   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 4) != 0);
      gap = ok ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 6));
      send_frame(b, ok);
      bus.din = 1'b1;
      repeat (gap) @(negedge clk);
    end
    bus.din = 1'b1;
    repeat (60) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("final_busy", int'(bus.busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
